// File: rtl/loop_nest_seq_pkg.sv
// rtl/loop_nest_seq_pkg.sv - shared widths, sequencer state and latched-bound types
package globals_sv;

  localparam int CLOG2K = 4;
  localparam int CLOG2W = 3;
  localparam int CLOG2L = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Last-value (inclusive) bounds captured at start, innermost level in the low bits
  typedef struct packed {
    logic [CLOG2L-1:0] l4;
    logic [CLOG2L-1:0] l3;
    logic [CLOG2L-1:0] l2;
    logic [CLOG2L-1:0] l1;
    logic [CLOG2L-1:0] l0;
    logic [CLOG2W-1:0] ckg;
    logic [CLOG2K-1:0] ksi;
  } bounds_t;

endpackage

// File: rtl/loop_nest_seq_loop_cnt.sv
// rtl/loop_nest_seq_loop_cnt.sv - one odometer digit: wraps at an inclusive bound and carries
module loop_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] bound,
  output logic [WIDTH-1:0] cnt,
  output logic             at_bound,
  output logic             carry
);

  assign at_bound = (cnt == bound);
  assign carry    = en & at_bound;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_bound ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/loop_nest_seq.sv
// rtl/loop_nest_seq.sv - seven-level loop nest sequencer (KSI innermost .. L4 outermost)
module loop_nest_seq
  import globals_sv::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              c1_c2_n,
  input  logic [CLOG2K-1:0] arv_KSI,
  input  logic [CLOG2W-1:0] arv_CKG,
  input  logic [CLOG2L-1:0] arv_L0,
  input  logic [CLOG2L-1:0] arv_L1,
  input  logic [CLOG2L-1:0] arv_L2,
  input  logic [CLOG2L-1:0] arv_L3,
  input  logic [CLOG2L-1:0] arv_L4,
  input  logic              dp_ready,
  output logic              it_valid,
  output logic [CLOG2K-1:0] cnt_KSI,
  output logic [CLOG2W-1:0] cnt_CKG,
  output logic [CLOG2L-1:0] cnt_L0,
  output logic [CLOG2L-1:0] cnt_L1,
  output logic [CLOG2L-1:0] cnt_L2,
  output logic [CLOG2L-1:0] cnt_L3,
  output logic [CLOG2L-1:0] cnt_L4,
  output logic              acc_first,
  output logic              acc_last,
  output logic              nest_last,
  output logic              mode_q,
  output logic              busy,
  output logic              done
);

  seq_state_t state, state_nx;
  bounds_t    bnd;
  logic       latch, clr, advance, all_bound;
  logic [6:0] en, at_b, carry;

  assign latch     = (state == IDLE) & start & ~abort;
  assign advance   = (state == RUN) & dp_ready & ~abort;
  assign all_bound = &at_b;
  // Counters return to zero whenever the sequencer heads back to IDLE
  assign clr       = abort | latch | (state == DONE);

  // The final acceptance freezes the odometer so the last index stays visible
  assign en[0]   = advance & ~all_bound;
  assign en[6:1] = carry[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = RUN;
        RUN:     if (advance && all_bound) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    it_valid  = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    acc_first = (state == RUN) & (cnt_KSI == '0);
    acc_last  = (state == RUN) & at_b[0];
    nest_last = (state == RUN) & all_bound;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bnd    <= '0;
      mode_q <= 1'b0;
    end else if (abort || state == DONE) begin
      bnd    <= '0;
      mode_q <= 1'b0;
    end else if (latch) begin
      bnd    <= '{l4: arv_L4, l3: arv_L3, l2: arv_L2, l1: arv_L1, l0: arv_L0,
                  ckg: arv_CKG, ksi: arv_KSI};
      mode_q <= c1_c2_n;
    end
  end

  loop_cnt #(.WIDTH(CLOG2K)) u_ksi (
    .clk(clk), .rst(rst), .clr(clr), .en(en[0]), .bound(bnd.ksi),
    .cnt(cnt_KSI), .at_bound(at_b[0]), .carry(carry[0])
  );

  loop_cnt #(.WIDTH(CLOG2W)) u_ckg (
    .clk(clk), .rst(rst), .clr(clr), .en(en[1]), .bound(bnd.ckg),
    .cnt(cnt_CKG), .at_bound(at_b[1]), .carry(carry[1])
  );

  loop_cnt #(.WIDTH(CLOG2L)) u_l0 (
    .clk(clk), .rst(rst), .clr(clr), .en(en[2]), .bound(bnd.l0),
    .cnt(cnt_L0), .at_bound(at_b[2]), .carry(carry[2])
  );

  loop_cnt #(.WIDTH(CLOG2L)) u_l1 (
    .clk(clk), .rst(rst), .clr(clr), .en(en[3]), .bound(bnd.l1),
    .cnt(cnt_L1), .at_bound(at_b[3]), .carry(carry[3])
  );

  loop_cnt #(.WIDTH(CLOG2L)) u_l2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en[4]), .bound(bnd.l2),
    .cnt(cnt_L2), .at_bound(at_b[4]), .carry(carry[4])
  );

  loop_cnt #(.WIDTH(CLOG2L)) u_l3 (
    .clk(clk), .rst(rst), .clr(clr), .en(en[5]), .bound(bnd.l3),
    .cnt(cnt_L3), .at_bound(at_b[5]), .carry(carry[5])
  );

  loop_cnt #(.WIDTH(CLOG2L)) u_l4 (
    .clk(clk), .rst(rst), .clr(clr), .en(en[6]), .bound(bnd.l4),
    .cnt(cnt_L4), .at_bound(at_b[6]), .carry(carry[6])
  );

  // The outermost carry can never fire: the final step is caught as DONE instead
  assert property (@(posedge clk) disable iff (rst) !carry[6]);

endmodule

// File: tb/tb_loop_nest_seq.sv
// tb/tb_loop_nest_seq.sv - directed self-checking bench for loop_nest_seq
module tb_loop_nest_seq;
  import globals_sv::*;

  logic              clk = 1'b0;
  logic              rst, start, abort, c1_c2_n, dp_ready;
  logic [CLOG2K-1:0] arv_KSI, cnt_KSI;
  logic [CLOG2W-1:0] arv_CKG, cnt_CKG;
  logic [CLOG2L-1:0] arv_L0, arv_L1, arv_L2, arv_L3, arv_L4;
  logic [CLOG2L-1:0] cnt_L0, cnt_L1, cnt_L2, cnt_L3, cnt_L4;
  logic              it_valid, acc_first, acc_last, nest_last, mode_q, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  loop_nest_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .c1_c2_n(c1_c2_n),
    .arv_KSI(arv_KSI), .arv_CKG(arv_CKG), .arv_L0(arv_L0), .arv_L1(arv_L1),
    .arv_L2(arv_L2), .arv_L3(arv_L3), .arv_L4(arv_L4), .dp_ready(dp_ready),
    .it_valid(it_valid), .cnt_KSI(cnt_KSI), .cnt_CKG(cnt_CKG), .cnt_L0(cnt_L0),
    .cnt_L1(cnt_L1), .cnt_L2(cnt_L2), .cnt_L3(cnt_L3), .cnt_L4(cnt_L4),
    .acc_first(acc_first), .acc_last(acc_last), .nest_last(nest_last),
    .mode_q(mode_q), .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] idx_vec();
    return {cnt_L4, cnt_L3, cnt_L2, cnt_L1, cnt_L0, cnt_CKG, cnt_KSI};
  endfunction

  function automatic logic [6:0] flag_vec();
    return {it_valid, acc_first, acc_last, nest_last, busy, done, mode_q};
  endfunction

  function automatic logic [21:0] mk(input int ksi, input int ckg, input int l0, input int l4);
    logic [CLOG2K-1:0] k;
    logic [CLOG2W-1:0] c;
    logic [CLOG2L-1:0] a, e;
    k = CLOG2K'(ksi);
    c = CLOG2W'(ckg);
    a = CLOG2L'(l0);
    e = CLOG2L'(l4);
    return {e, 3'd0, 3'd0, 3'd0, a, c, k};
  endfunction

  task automatic set_bounds(input int ksi, input int ckg, input int l0, input int l4);
    arv_KSI = CLOG2K'(ksi);
    arv_CKG = CLOG2W'(ckg);
    arv_L0  = CLOG2L'(l0);
    arv_L1  = '0;
    arv_L2  = '0;
    arv_L3  = '0;
    arv_L4  = CLOG2L'(l4);
  endtask

  task automatic load_six();
    exp_q = {};
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(0, 2, 0, 0));
    exp_q.push_back(mk(1, 2, 0, 0));
  endtask

  // pat 0: dp_ready always 1; pat 1: 1,0,0 repeating over RUN cycles
  task automatic run_nest(input string name, input int pat, input bit repulse, input bit scramble,
                          input logic exp_mode, input int bksi, input int max_cyc);
    int          got, dones, k;
    bit          fin, prev_hold;
    logic [28:0] prev, snap;
    logic [21:0] cur;
    got = 0; dones = 0; k = 0; fin = 0; prev_hold = 0; prev = '0;
    @(negedge clk);
    start = 1'b1;
    dp_ready = 1'b1;
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      @(negedge clk);
      snap = {flag_vec(), idx_vec()};
      cur  = idx_vec();
      if (prev_hold) check_eq({name, "_hold"}, snap, prev);
      if (busy) check_eq({name, "_mode_q"}, mode_q, exp_mode);
      if (done) dones++;
      if (dones > 0 && !done) begin
        check_eq({name, "_idle_after_done"}, {25'd0, flag_vec()}, 0);
        fin = 1;
      end
      start = repulse && busy;
      if (scramble && busy) begin
        arv_KSI = CLOG2K'($urandom_range(15, 0));
        arv_CKG = CLOG2W'($urandom_range(7, 0));
        arv_L0  = CLOG2L'($urandom_range(7, 0));
        arv_L4  = CLOG2L'($urandom_range(7, 0));
      end
      if (it_valid) begin
        dp_ready = (pat == 0) ? 1'b1 : ((k % 3) == 0);
        k++;
      end else begin
        dp_ready = 1'b1;
      end
      if (it_valid && dp_ready) begin
        if (got < exp_q.size()) begin
          check_eq({name, "_idx"}, cur, exp_q[got]);
          check_eq({name, "_acc_first"}, acc_first, cur[CLOG2K-1:0] == 0);
          check_eq({name, "_acc_last"}, acc_last, cur[CLOG2K-1:0] == CLOG2K'(bksi));
          check_eq({name, "_nest_last"}, nest_last, got == exp_q.size() - 1);
        end
        got++;
      end
      prev_hold = it_valid && !dp_ready;
      prev = snap;
    end
    start = 1'b0;
    check_eq({name, "_iters"}, got, exp_q.size());
    check_eq({name, "_done_cnt"}, dones, 1);
    if (!fin) check_eq({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; c1_c2_n = 1'b0; dp_ready = 1'b0;
    set_bounds(0, 0, 0, 0);
    #12;
    check_eq("reset_flags", {25'd0, flag_vec()}, 0);
    check_eq("reset_idx", idx_vec(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_flags", {25'd0, flag_vec()}, 0);

    // single-pass nest
    exp_q = {};
    exp_q.push_back(mk(0, 0, 0, 0));
    run_nest("all_zero", 0, 0, 0, 1'b0, 0, 20);

    // KSI x CKG = 2 x 3
    set_bounds(1, 2, 0, 0);
    load_six();
    run_nest("ksi_ckg", 0, 0, 0, 1'b0, 1, 40);

    // L0 and L4 with stalls
    set_bounds(0, 0, 1, 1);
    exp_q = {};
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 1, 1));
    run_nest("l0_l4_stall", 1, 0, 0, 1'b0, 0, 60);

    // start re-pulsed and bounds scrambled while running
    set_bounds(1, 2, 0, 0);
    load_six();
    run_nest("repulse", 0, 1, 1, 1'b0, 1, 40);

    // abort on the third iteration
    set_bounds(1, 2, 0, 0);
    @(negedge clk);
    start = 1'b1;
    dp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_pre_idx", idx_vec(), mk(0, 1, 0, 0));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_flags", {25'd0, flag_vec()}, 0);
    check_eq("abort_idx", idx_vec(), 0);
    @(negedge clk);
    check_eq("abort_no_done", {25'd0, flag_vec()}, 0);
    run_nest("after_abort", 0, 0, 0, 1'b0, 1, 40);

    // mode echo and asynchronous reset mid-run
    c1_c2_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    dp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("mode_run0", mode_q, 1);
    @(negedge clk);
    check_eq("mode_run1", mode_q, 1);
    check_eq("pre_rst_idx", idx_vec(), mk(1, 0, 0, 0));
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_flags", {25'd0, flag_vec()}, 0);
    check_eq("async_rst_idx", idx_vec(), 0);
    @(negedge clk);
    rst = 1'b0;
    run_nest("mode_full", 0, 0, 0, 1'b1, 1, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/loop_nest_seq.md
# loop_nest_seq

Sequencer that walks the NPU's seven-level compute loop nest: KSI, CKG, L0, L1, L2, L3, L4, innermost to outermost. It latches the per-layer loop bounds produced by the parameter block for the selected convolution mode (`c1_c2_n`). It then issues one iteration index per accepted cycle to the datapath and address generators, with accumulator first/last markers, and reports completion with a one-cycle done pulse.

## Interface
Parameters (widths come from `globals_sv`; no local parameters):
- CLOG2K, package value: KSI counter/bound width
- CLOG2W, package value: CKG counter/bound width
- CLOG2L, package value: L0..L4 counter/bound width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a loop nest; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- c1_c2_n  in  1  mode tag, latched at start, echoed on `mode_q`
- arv_KSI  in  CLOG2K  last KSI value (inclusive), latched at start
- arv_CKG  in  CLOG2W  last CKG value (inclusive), latched at start
- arv_L0..arv_L4  in  CLOG2L each  last L0..L4 values (inclusive), latched at start
- dp_ready  in  1  datapath accepts the current iteration this cycle
- it_valid  out  1  current index set is valid
- cnt_KSI  out  CLOG2K  current KSI index
- cnt_CKG  out  CLOG2W  current CKG index
- cnt_L0..cnt_L4  out  CLOG2L each  current L0..L4 indices
- acc_first  out  1  cnt_KSI==0 and it_valid
- acc_last  out  1  cnt_KSI==bound_KSI and it_valid
- nest_last  out  1  every counter at its bound and it_valid
- mode_q  out  1  latched c1_c2_n
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final iteration is accepted

## Operation
- States: IDLE, RUN, DONE. Encoded as typedef `seq_state_t`.
- IDLE:
  - start=1 latches all bounds and the mode, clears all counters, and moves to RUN.
  - start is ignored in RUN and DONE.
- RUN:
  - it_valid=1.
  - Advance occurs when dp_ready=1.
  - On advance, KSI increments. When KSI equals its bound, it wraps to 0 and carries to CKG. The same rule applies up the chain to L4 (odometer order).
  - Advance with nest_last=1 moves to DONE and leaves the counters unchanged.
  - dp_ready=0 holds every output stable.
- DONE:
  - it_valid=0, done=1 for exactly one cycle, then IDLE.
- abort=1 in any state: next state is IDLE, counters cleared, no done pulse. abort has priority over start and advance.
- A bound of 0 makes that level single-pass; it carries on every advance.
- Total accepted iterations = product of (arv_x+1) over all seven levels.
- Compares are equality against the latched bounds, at the latched width. Bound inputs changing during RUN have no effect.
- Latched bounds are not range-checked. A bound at all-ones is legal (full counter range).

## Timing
- Reset values (also the abort/IDLE values):
  - state=IDLE
  - all cnt_*=0
  - it_valid, acc_first, acc_last, nest_last, busy, done, mode_q = 0
  - latched bounds = 0
- All outputs are registered. The flags are derived from registered counters and the registered state only; there is no combinational path from dp_ready to any output.
- start at edge t produces RUN, it_valid=1 and indices all 0 from t+1.
- Each iteration is presented until accepted. Throughput is 1 iteration/cycle at dp_ready=1.
- Final acceptance at edge t gives done=1 during t+1 and IDLE at t+2. A new start is accepted from t+2.
- Reset asserted mid-RUN clears state immediately, asynchronously. Deassertion is synchronized externally by the top level.

## Structure
- Add `seq_state_t` to `globals_sv`. CLOG2K/CLOG2W/CLOG2L are already there.
- One sub-module, `loop_cnt`:
  - parameter WIDTH
  - inputs: clk, rst, clr, en, bound
  - outputs: cnt, at_bound, carry = en & at_bound
- Instantiate `loop_cnt` seven times, chaining each carry into the next level's en.
- The FSM and flag registers live in `loop_nest_seq`.

## Test plan
- All bounds 0, start pulse, dp_ready=1 -> exactly one it_valid cycle with acc_first=acc_last=nest_last=1; done one cycle later; IDLE after.
- arv_KSI=1, arv_CKG=2, others 0, dp_ready=1 -> 6 iterations (KSI,CKG) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); acc_first on even indices, acc_last on odd; nest_last only on the 6th.
- arv_L0=1, arv_L4=1, others 0, dp_ready toggled 1,0,0,1,... -> 4 iterations in odometer order; outputs held during every dp_ready=0 cycle; done count=1.
- start re-pulsed during RUN, and bound inputs changed mid-run -> sequence and iteration count unchanged.
- abort asserted on iteration 3 of 6 -> IDLE next cycle, counters 0, no done; then a fresh start runs all 6.
- rst asserted asynchronously mid-RUN -> all outputs 0 before the next edge; with c1_c2_n=1 at start, mode_q=1 throughout the run.
